// File: rtl/scdmem_io.sv
// Data-side memory for the single-cycle CPU: word RAM, free-running cycle counter and a
// buffered byte-stream TX port, all memory-mapped with zero-latency combinational reads.
module scdmem_io #(
    parameter int AW      = 10,
    parameter int FIFO_AW = 2
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic [31:0] rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

    typedef enum logic [1:0] {
        REG_CYCLE  = 2'd0,
        REG_TX     = 2'd1,
        REG_STATUS = 2'd2,
        REG_RSVD   = 2'd3
    } io_reg_e;

    logic [31:0]        ram [2**AW];
    logic [7:0]         fifo_mem [DEPTH];
    logic [31:0]        cycle_cnt;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW:0]   count;
    logic               overflow;

    logic               is_io;
    io_reg_e            io_sel;
    logic [AW-1:0]      ram_idx;
    logic               ram_we;
    logic               cycle_we;
    logic               status_we;
    logic               push;
    logic               pop;
    logic               push_ok;
    logic               drop;
    logic               full;
    logic               empty;
    logic               unused_addr_bits;

    assign is_io   = addr[31];
    assign io_sel  = io_reg_e'(addr[3:2]);
    assign ram_idx = addr[AW+1:2];

    // Upper RAM address bits alias and the byte offset is ignored.
    assign unused_addr_bits = ^{addr[30:AW+2], addr[1:0]};

    assign ram_we    = we & ~is_io;
    assign cycle_we  = we & is_io & (io_sel == REG_CYCLE);
    assign status_we = we & is_io & (io_sel == REG_STATUS);
    assign push      = we & is_io & (io_sel == REG_TX);

    assign full     = (count == CNT_FULL);
    assign empty    = (count == '0);
    assign tx_valid = ~empty;
    assign tx_data  = tx_valid ? fifo_mem[rd_ptr] : 8'h00;

    // A pop frees a slot in the same edge, so a full FIFO can still take a push.
    assign pop     = tx_valid & tx_ready;
    assign push_ok = push & (~full | pop);
    assign drop    = push & full & ~pop;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_idx] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= wdata[7:0];
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cycle_cnt <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
        end else begin
            if (cycle_we) begin
                cycle_cnt <= wdata;
            end else begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end

            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end

            case ({push_ok, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase

            // A dropped byte outranks a clear issued in the same cycle.
            if (drop) begin
                overflow <= 1'b1;
            end else if (status_we) begin
                overflow <= 1'b0;
            end
        end
    end

    always_comb begin
        rdata = 32'h0;
        if (!is_io) begin
            rdata = ram[ram_idx];
        end else begin
            case (io_sel)
                REG_CYCLE:  rdata = cycle_cnt;
                REG_STATUS: rdata = {28'b0, overflow, full, empty, tx_valid};
                default:    rdata = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_scdmem_io.sv
// Self-checking bench for scdmem_io: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue/array-based reference model.
module tb_scdmem_io;

    localparam logic [31:0] A_CYCLE  = 32'h8000_0000;
    localparam logic [31:0] A_TX     = 32'h8000_0004;
    localparam logic [31:0] A_STATUS = 32'h8000_0008;
    localparam logic [31:0] A_RSVD   = 32'h8000_000C;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        we = 1'b0;
    logic        tx_ready = 1'b0;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;

    int n_vectors = 0;
    int n_miscompares = 0;

    scdmem_io #(.AW(10), .FIFO_AW(2)) dut (
        .clk      (clk),
        .clrn     (clrn),
        .addr     (addr),
        .wdata    (wdata),
        .we       (we),
        .rdata    (rdata),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    always #5 clk = ~clk;

    // Reference model: RAM as an array with written-flags, FIFO as a byte queue.
    logic [31:0] m_ram [1024];
    bit          m_known [1024];
    logic [31:0] m_cycle;
    logic [7:0]  m_q [$];
    bit          m_ov;

    function automatic logic [31:0] modelRead(input logic [31:0] a);
        logic [31:0] v;
        v = 32'h0;
        if (!a[31]) begin
            v = m_ram[a[11:2]];
        end else if (a[3:2] == 2'd0) begin
            v = m_cycle;
        end else if (a[3:2] == 2'd2) begin
            v = {28'b0, m_ov, m_q.size() == 4, m_q.size() == 0, m_q.size() != 0};
        end
        return v;
    endfunction

    always @(posedge clk or negedge clrn) begin
        int  sz;
        bit  pop_now;
        bit  push_now;
        bit  drop_now;
        if (!clrn) begin
            m_cycle = 32'h0;
            m_q.delete();
            m_ov = 1'b0;
        end else begin
            sz       = m_q.size();
            pop_now  = (sz > 0) && tx_ready;
            push_now = we && addr[31] && (addr[3:2] == 2'd1);
            drop_now = push_now && (sz == 4) && !pop_now;
            if (we && !addr[31]) begin
                m_ram[addr[11:2]]   = wdata;
                m_known[addr[11:2]] = 1'b1;
            end
            if (we && addr[31] && addr[3:2] == 2'd0) m_cycle = wdata;
            else                                   m_cycle = m_cycle + 32'd1;
            if (pop_now) void'(m_q.pop_front());
            if (push_now && !drop_now) m_q.push_back(wdata[7:0]);
            if (drop_now) m_ov = 1'b1;
            else if (we && addr[31] && addr[3:2] == 2'd2) m_ov = 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Inputs change just after the falling edge and settle well before the next rising edge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d,
                                 input logic w, input logic r);
        @(negedge clk);
        #1;
        addr     = a;
        wdata    = d;
        we       = w;
        tx_ready = r;
        #1;
    endtask

    always @(negedge clk) begin
        if (clrn) begin
            if (addr[31] || m_known[addr[11:2]]) begin
                checkOutput("model_rdata", rdata, modelRead(addr));
            end
            checkOutput("model_tx_valid", {31'b0, tx_valid}, {31'b0, m_q.size() != 0});
            checkOutput("model_tx_data", {24'b0, tx_data},
                        {24'b0, (m_q.size() != 0) ? m_q[0] : 8'h00});
        end
    end

    logic [7:0] drain_exp [4] = '{8'h42, 8'h43, 8'h44, 8'h55};

    initial begin
        logic [31:0] a;
        logic        w;
        logic        r;
        int          kind;

        // Reset state
        applyStimulus(A_CYCLE, 32'h0, 1'b0, 1'b0);
        checkOutput("reset_cycle", rdata, 32'h0);
        checkOutput("reset_tx_valid", {31'b0, tx_valid}, 32'h0);
        checkOutput("reset_tx_data", {24'b0, tx_data}, 32'h0);
        applyStimulus(A_STATUS, 32'h0, 1'b0, 1'b0);
        checkOutput("reset_status", rdata, 32'h2);
        clrn = 1'b1;

        // Cycle counter run and wrap
        applyStimulus(A_CYCLE, 32'h0, 1'b0, 1'b0);
        checkOutput("cycle_first", rdata, 32'd1);
        repeat (5) applyStimulus(A_CYCLE, 32'h0, 1'b0, 1'b0);
        checkOutput("cycle_plus5", rdata, 32'd6);
        applyStimulus(A_CYCLE, 32'hFFFF_FFFE, 1'b1, 1'b0);
        checkOutput("cycle_write_old", rdata, 32'd7);
        applyStimulus(A_CYCLE, 32'h0, 1'b0, 1'b0);
        checkOutput("cycle_wr_value", rdata, 32'hFFFF_FFFE);
        applyStimulus(A_CYCLE, 32'h0, 1'b0, 1'b0);
        checkOutput("cycle_max", rdata, 32'hFFFF_FFFF);
        applyStimulus(A_CYCLE, 32'h0, 1'b0, 1'b0);
        checkOutput("cycle_wrap0", rdata, 32'h0);
        applyStimulus(A_CYCLE, 32'h0, 1'b0, 1'b0);
        checkOutput("cycle_wrap1", rdata, 32'h1);

        // RAM store/load, same-cycle old value, aliasing
        applyStimulus(32'h0000_0010, 32'h1111_1111, 1'b1, 1'b0);
        applyStimulus(32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0);
        checkOutput("ram_same_cycle_old", rdata, 32'h1111_1111);
        applyStimulus(32'h0000_0010, 32'h0, 1'b0, 1'b0);
        checkOutput("ram_load", rdata, 32'hDEAD_BEEF);
        applyStimulus(32'h0000_1010, 32'h0, 1'b0, 1'b0);
        checkOutput("ram_alias", rdata, 32'hDEAD_BEEF);

        // Fill FIFO, overflow, clear
        for (int i = 0; i < 4; i++) applyStimulus(A_TX, 32'h41 + i, 1'b1, 1'b0);
        applyStimulus(A_STATUS, 32'h0, 1'b0, 1'b0);
        checkOutput("fifo_full_status", rdata, 32'h5);
        checkOutput("fifo_full_head", {24'b0, tx_data}, 32'h41);
        applyStimulus(A_TX, 32'h45, 1'b1, 1'b0);
        applyStimulus(A_STATUS, 32'h0, 1'b0, 1'b0);
        checkOutput("fifo_overflow_status", rdata, 32'hD);
        checkOutput("fifo_overflow_head", {24'b0, tx_data}, 32'h41);
        applyStimulus(A_STATUS, 32'h0, 1'b1, 1'b0);
        checkOutput("status_clear_old", rdata, 32'hD);
        applyStimulus(A_STATUS, 32'h0, 1'b0, 1'b0);
        checkOutput("status_cleared", rdata, 32'h5);

        // Push and pop together while full, then drain
        applyStimulus(A_TX, 32'h55, 1'b1, 1'b1);
        checkOutput("pushpop_head", {24'b0, tx_data}, 32'h41);
        applyStimulus(A_STATUS, 32'h0, 1'b0, 1'b0);
        checkOutput("pushpop_status", rdata, 32'h5);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(A_STATUS, 32'h0, 1'b0, 1'b1);
            checkOutput("drain_data", {24'b0, tx_data}, {24'b0, drain_exp[i]});
            checkOutput("drain_valid", {31'b0, tx_valid}, 32'h1);
        end
        applyStimulus(A_STATUS, 32'h0, 1'b0, 1'b0);
        checkOutput("drained_status", rdata, 32'h2);
        checkOutput("drained_valid", {31'b0, tx_valid}, 32'h0);

        // Asynchronous reset in the middle of a drain
        for (int i = 0; i < 3; i++) applyStimulus(A_TX, 32'h61 + i, 1'b1, 1'b0);
        applyStimulus(A_CYCLE, 32'h0, 1'b0, 1'b1);
        applyStimulus(A_CYCLE, 32'h0, 1'b0, 1'b1);
        checkOutput("predrain_head", {24'b0, tx_data}, 32'h62);
        #1 clrn = 1'b0;
        #1;
        checkOutput("async_tx_valid", {31'b0, tx_valid}, 32'h0);
        checkOutput("async_cycle", rdata, 32'h0);
        @(posedge clk);
        #1 clrn = 1'b1;
        applyStimulus(A_STATUS, 32'h0, 1'b0, 1'b0);
        checkOutput("post_reset_status", rdata, 32'h2);

        // Reserved/TX reads and byte-offset stores
        applyStimulus(A_RSVD, 32'hFFFF_FFFF, 1'b1, 1'b0);
        checkOutput("rsvd_read", rdata, 32'h0);
        applyStimulus(A_TX, 32'h0, 1'b0, 1'b0);
        checkOutput("tx_reg_read", rdata, 32'h0);
        applyStimulus(A_STATUS, 32'h0, 1'b0, 1'b0);
        checkOutput("rsvd_no_effect", rdata, 32'h2);
        applyStimulus(32'h0000_0013, 32'hCAFE_F00D, 1'b1, 1'b0);
        applyStimulus(32'h0000_0010, 32'h0, 1'b0, 1'b0);
        checkOutput("ram_byte_offset", rdata, 32'hCAFE_F00D);

        // Randomized traffic checked by the model every cycle
        for (int n = 0; n < 800; n++) begin
            kind = $urandom_range(0, 9);
            w    = 1'b0;
            if (kind <= 3) begin
                a = {1'b0, 19'($urandom), 6'b0, 4'($urandom), 2'($urandom)};
                w = $urandom_range(0, 1) == 1;
            end else if (kind <= 6) begin
                a = {1'b1, 27'($urandom), 2'd1, 2'($urandom)};
                w = $urandom_range(0, 1) == 1;
            end else begin
                a = {1'b1, 27'($urandom), 2'($urandom_range(0, 3)), 2'($urandom)};
                w = $urandom_range(0, 7) == 0;
            end
            if (n < 400) r = $urandom_range(0, 3) == 0;
            else         r = $urandom_range(0, 3) != 0;
            applyStimulus(a, $urandom, w, r);
        end

        applyStimulus(A_STATUS, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
